// File: rtl/seed_sbox_sched.sv
// ---------------------------------------------------------------------------
// seed_sbox_sched
//
// Shares one combinational GF(2^8) inversion/affine S-box unit between the
// two G-function requesters of the 8-bit serialized SEED core: the round
// datapath (requester 0) and the key schedule (requester 1).
//
// A granted 32-bit word is pushed through the shared unit one byte per
// cycle. Even bytes use S1 and odd bytes use S2. The S-box constant is
// XORed onto each result byte here, and the reassembled word is returned
// to its owner together with a one-cycle done pulse.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req0/req1    request levels (datapath / key schedule)
//   din0/din1    32-bit G-input words, stable while requesting
//   gnt0/gnt1    combinational acceptance strobes, IDLE only
//   done0/done1  one-cycle result-valid pulses to the owner
//   dout         substituted word, held until the next result
//   busy         high while an operation is in RUN or DONE
//   sb_x/sb_ch   byte and S1/S2 select driven to the shared unit
//   sb_y         shared unit result, without the constant
// ---------------------------------------------------------------------------
module seed_sbox_sched #(
    parameter logic [7:0] S1_CONST = 8'hA9,
    parameter logic [7:0] S2_CONST = 8'h38
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] din0,
    input  logic [31:0] din1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] dout,
    output logic        busy,
    output logic [7:0]  sb_x,
    output logic        sb_ch,
    input  logic [7:0]  sb_y
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic [31:0] word;
    logic [31:0] res;
    logic        owner;
    logic        last;

    logic        in_idle;
    logic        in_run;
    logic        in_done;
    logic        win1;
    logic [7:0]  sb_out;

    assign in_idle = (state == ST_IDLE);
    assign in_run  = (state == ST_RUN);
    assign in_done = (state == ST_DONE);

    // Round-robin: requester 1 wins when it is alone, or on a tie when
    // requester 0 was the last one served (last == 0).
    assign win1 = req1 & (~req0 | ~last);

    // Grants are masked by rst so that a held request does not show a
    // grant while the block is being reset.
    assign gnt1 = in_idle & ~rst & win1;
    assign gnt0 = in_idle & ~rst & req0 & ~win1;

    assign done0 = in_done & ~owner;
    assign done1 = in_done & owner;
    assign busy  = in_run | in_done;

    // The shared-unit drive depends only on registered state so it never
    // glitches with requester activity. Even byte positions use S1.
    always_comb begin
        sb_x = 8'h00;
        if (in_run) begin
            sb_x = word[8*cnt +: 8];
        end
    end

    assign sb_ch  = in_run & ~cnt[0];
    assign sb_out = sb_y ^ (sb_ch ? S1_CONST : S2_CONST);

    // Sequencer: accept a word in IDLE, substitute four bytes in RUN,
    // present the result for one cycle in DONE. The final byte goes
    // straight into dout so that dout stays stable across later RUN phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            word  <= 32'h0;
            res   <= 32'h0;
            dout  <= 32'h0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        word  <= win1 ? din1 : din0;
                        owner <= win1;
                        last  <= win1;
                        cnt   <= 2'd0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res[8*cnt +: 8] <= sb_out;
                    cnt             <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        dout  <= {sb_out, res[23:0]};
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
